ram_dp_be_clr: RTL and testbench

//  Parametrised true dual-port synchronous RAM: byte enables, per-port enables, selectable read-during-write mode,

---
 rtl/ram_dp_be_clr_if.sv | 37 +++
 rtl/ram_dp_be_clr.sv | 153 +++++++++++++++
 tb/tb_ram_dp_be_clr.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ram_dp_be_clr_if.sv
// Port bundle for ram_dp_be_clr: two byte-enabled access ports, clear control and status.
// The parity signals exist only when RAM_PARITY_EN is defined.
interface ram_dp_be_clr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic                    en_a, we_a;
  logic [DATA_WIDTH/8-1:0] be_a;
  logic [ADDR_WIDTH-1:0]   addr_a;
  logic [DATA_WIDTH-1:0]   data_a, q_a;
  logic                    en_b, we_b;
  logic [DATA_WIDTH/8-1:0] be_b;
  logic [ADDR_WIDTH-1:0]   addr_b;
  logic [DATA_WIDTH-1:0]   data_b, q_b;
  logic                    clr_req, busy, collision;
`ifdef RAM_PARITY_EN
  logic                    inj_err, parity_err_a, parity_err_b;

  modport master (
    output en_a, we_a, be_a, addr_a, data_a, en_b, we_b, be_b, addr_b, data_b, clr_req, inj_err,
    input  q_a, q_b, busy, collision, parity_err_a, parity_err_b
  );
  modport slave (
    input  en_a, we_a, be_a, addr_a, data_a, en_b, we_b, be_b, addr_b, data_b, clr_req, inj_err,
    output q_a, q_b, busy, collision, parity_err_a, parity_err_b
  );
`else
  modport master (
    output en_a, we_a, be_a, addr_a, data_a, en_b, we_b, be_b, addr_b, data_b, clr_req,
    input  q_a, q_b, busy, collision
  );
  modport slave (
    input  en_a, we_a, be_a, addr_a, data_a, en_b, we_b, be_b, addr_b, data_b, clr_req,
    output q_a, q_b, busy, collision
  );
`endif
endinterface

// File: rtl/ram_dp_be_clr.sv
// True dual-port byte-enabled RAM with address-collision flag and a hardware clear engine.
// Optional per-lane even parity with error injection when RAM_PARITY_EN is defined.
//
// state    | meaning
// ST_CLEAR | clear engine writes CLR_VALUE to ram[clr_addr]; ports ignored, busy=1
// ST_IDLE  | both ports serviced; clr_req starts a new clear
module ram_dp_be_clr #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
  input logic            clk,
  input logic            rst_n,
  ram_dp_be_clr_if.slave bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                    busy;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    acc_a, acc_b;
  logic [NB-1:0]           wl_a, wl_b;
  logic [DATA_WIDTH-1:0]   old_a, old_b, rdw_a, rdw_b;
  logic [DATA_WIDTH-1:0]   q_a_q, q_b_q;
  logic                    collision_q;

  assign busy  = (state_q == ST_CLEAR);
  assign acc_a = bus.en_a & ~busy;
  assign acc_b = bus.en_b & ~busy;
  assign wl_a  = (acc_a & bus.we_a) ? bus.be_a : '0;
  assign wl_b  = (acc_b & bus.we_b) ? bus.be_b : '0;
  assign old_a = mem[bus.addr_a];
  assign old_b = mem[bus.addr_b];

  // Write-first only substitutes this port's own written lanes; the other port is never bypassed.
  always_comb begin
    rdw_a = old_a;
    rdw_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (RDW_MODE == 0 && wl_a[i]) rdw_a[8*i +: 8] = bus.data_a[8*i +: 8];
      if (RDW_MODE == 0 && wl_b[i]) rdw_b[8*i +: 8] = bus.data_b[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (&clr_addr_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Port B lanes are written after port A so B wins on overlapping lanes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (busy) begin
        mem[clr_addr_q] <= CLR_VALUE;
      end else begin
        for (int i = 0; i < NB; i++)
          if (wl_a[i]) mem[bus.addr_a][8*i +: 8] <= bus.data_a[8*i +: 8];
        for (int i = 0; i < NB; i++)
          if (wl_b[i]) mem[bus.addr_b][8*i +: 8] <= bus.data_b[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_a_q       <= '0;
      q_b_q       <= '0;
      collision_q <= 1'b0;
    end else begin
      if (acc_a) q_a_q <= rdw_a;
      if (acc_b) q_b_q <= rdw_b;
      collision_q <= acc_a & acc_b & (bus.addr_a == bus.addr_b) & (bus.we_a | bus.we_b);
    end
  end

  assign bus.q_a       = q_a_q;
  assign bus.q_b       = q_b_q;
  assign bus.busy      = busy;
  assign bus.collision = collision_q;

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] clr_par, bad_a, bad_b;
  logic          perr_a_q, perr_b_q;

  always_comb begin
    clr_par = '0;
    bad_a   = '0;
    bad_b   = '0;
    for (int i = 0; i < NB; i++) begin
      clr_par[i] = ^CLR_VALUE[8*i +: 8];
      bad_a[i]   = (^old_a[8*i +: 8]) ^ par[bus.addr_a][i];
      bad_b[i]   = (^old_b[8*i +: 8]) ^ par[bus.addr_b][i];
      if (RDW_MODE == 0 && wl_a[i]) bad_a[i] = 1'b0;
      if (RDW_MODE == 0 && wl_b[i]) bad_b[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (busy) begin
        par[clr_addr_q] <= clr_par;
      end else begin
        for (int i = 0; i < NB; i++)
          if (wl_a[i]) par[bus.addr_a][i] <= (^bus.data_a[8*i +: 8]) ^ bus.inj_err;
        for (int i = 0; i < NB; i++)
          if (wl_b[i]) par[bus.addr_b][i] <= (^bus.data_b[8*i +: 8]) ^ bus.inj_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perr_a_q <= 1'b0;
      perr_b_q <= 1'b0;
    end else begin
      if (acc_a) perr_a_q <= |bad_a;
      if (acc_b) perr_b_q <= |bad_b;
    end
  end

  assign bus.parity_err_a = perr_a_q;
  assign bus.parity_err_b = perr_b_q;
`endif
endmodule

// File: tb/tb_ram_dp_be_clr.sv
// Directed plus randomized bench for ram_dp_be_clr against a word-array reference model.
module tb_ram_dp_be_clr;
  localparam int DW = 32, AW = 6, RDW = 0, DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_dp_be_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  ram_dp_be_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(RDW), .CLR_VALUE(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int checks = 0, errors = 0;
  logic [31:0] mdl [DEPTH];
  logic [3:0]  mbad [DEPTH];
  int          busy_cnt = DEPTH;
  logic [31:0] eqa = 0, eqb = 0;
  logic        ecol = 0, epa = 0, epb = 0;
  logic        inj = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic drv_a(input logic en, we, input logic [3:0] be, input logic [5:0] a, input logic [31:0] d);
    bus.en_a = en; bus.we_a = we; bus.be_a = be; bus.addr_a = a; bus.data_a = d;
  endtask

  task automatic drv_b(input logic en, we, input logic [3:0] be, input logic [5:0] a, input logic [31:0] d);
    bus.en_b = en; bus.we_b = we; bus.be_b = be; bus.addr_b = a; bus.data_b = d;
  endtask

  // Advance the model by one edge from the currently driven inputs, clock the DUT, compare.
  task automatic step();
    logic [3:0]  wa, wb;
    logic [31:0] ma, mb, oa, ob;
    if (!rst_n) begin
      busy_cnt = DEPTH; eqa = 0; eqb = 0; ecol = 0; epa = 0; epb = 0;
      for (int k = 0; k < DEPTH; k++) begin mdl[k] = 0; mbad[k] = 0; end
    end else if (busy_cnt > 0) begin
      busy_cnt--; ecol = 0;
    end else begin
      wa = (bus.en_a && bus.we_a) ? bus.be_a : 4'h0;
      wb = (bus.en_b && bus.we_b) ? bus.be_b : 4'h0;
      ma = lanes(wa); mb = lanes(wb);
      oa = mdl[bus.addr_a]; ob = mdl[bus.addr_b];
      ecol = bus.en_a && bus.en_b && (bus.addr_a == bus.addr_b) && (bus.we_a || bus.we_b);
      if (bus.en_a) begin
        eqa = (RDW == 0) ? ((oa & ~ma) | (bus.data_a & ma)) : oa;
        epa = (RDW == 0) ? |(mbad[bus.addr_a] & ~wa) : |mbad[bus.addr_a];
      end
      if (bus.en_b) begin
        eqb = (RDW == 0) ? ((ob & ~mb) | (bus.data_b & mb)) : ob;
        epb = (RDW == 0) ? |(mbad[bus.addr_b] & ~wb) : |mbad[bus.addr_b];
      end
      mdl[bus.addr_a]  = (mdl[bus.addr_a] & ~ma) | (bus.data_a & ma);
      mbad[bus.addr_a] = (mbad[bus.addr_a] & ~wa) | (wa & {4{inj}});
      mdl[bus.addr_b]  = (mdl[bus.addr_b] & ~mb) | (bus.data_b & mb);
      mbad[bus.addr_b] = (mbad[bus.addr_b] & ~wb) | (wb & {4{inj}});
      if (bus.clr_req) begin
        busy_cnt = DEPTH;
        for (int k = 0; k < DEPTH; k++) begin mdl[k] = 0; mbad[k] = 0; end
      end
    end
    @(posedge clk); #1;
    chk("q_a", bus.q_a, eqa);
    chk("q_b", bus.q_b, eqb);
    chk("busy", 32'(bus.busy), 32'(busy_cnt > 0));
    chk("collision", 32'(bus.collision), 32'(ecol));
`ifdef RAM_PARITY_EN
    chk("parity_err_a", 32'(bus.parity_err_a), 32'(epa));
    chk("parity_err_b", 32'(bus.parity_err_b), 32'(epb));
`endif
  endtask

  task automatic rand_ports();
    drv_a(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 4'($urandom), 6'($urandom_range(7, 0)), $urandom);
    drv_b(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 4'($urandom), 6'($urandom_range(7, 0)), $urandom);
    inj = ($urandom_range(7, 0) == 0);
  endtask

`ifdef RAM_PARITY_EN
  assign bus.inj_err = inj;
`endif

  initial begin
    int n;
    drv_a(0, 0, 0, 0, 0); drv_b(0, 0, 0, 0, 0); bus.clr_req = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b1;

    n = 0;
    while (bus.busy && n < 200) begin step(); n++; end
    chk("clr_len_reset", 32'(n), 32'd64);

    drv_a(1, 0, 0, 0, 0);  step(); chk("rd0", bus.q_a, 32'h0);
    drv_a(1, 0, 0, 17, 0); step(); chk("rd17", bus.q_a, 32'h0);
    drv_a(1, 0, 0, 63, 0); step(); chk("rd63", bus.q_a, 32'h0);

    drv_a(1, 1, 4'hF, 5, 32'hDEADBEEF); step();
    drv_a(1, 1, 4'b0010, 5, 32'h00001200); step();
    drv_a(1, 0, 0, 5, 0); step();
    chk("be_merge", bus.q_a, 32'hDEAD12EF);
    drv_a(1, 1, 4'h0, 5, 32'hFFFFFFFF); step();
    chk("be_zero_is_read", bus.q_a, 32'hDEAD12EF);

    drv_a(1, 1, 4'hF, 9, 32'h11111111); step();
    chk("rdw_same_port", bus.q_a, (RDW == 0) ? 32'h11111111 : 32'h0);
    drv_a(0, 1, 4'hF, 9, 32'h22222222); step();
    chk("q_hold_en0", bus.q_a, (RDW == 0) ? 32'h11111111 : 32'h0);

    drv_a(1, 1, 4'h3, 3, 32'hAAAAAAAA); drv_b(1, 1, 4'h6, 3, 32'hBBBBBBBB); step();
    chk("ww_collision", 32'(bus.collision), 32'd1);
    drv_a(1, 0, 0, 3, 0); drv_b(0, 0, 0, 0, 0); step();
    chk("ww_merge", bus.q_a, 32'h00BBBBAA);
    chk("collision_pulse", 32'(bus.collision), 32'd0);

    drv_a(1, 1, 4'hF, 7, 32'h5); step();
    drv_a(1, 1, 4'hF, 7, 32'h12345678); drv_b(1, 0, 0, 7, 0); step();
    chk("xport_old", bus.q_b, 32'h5);
    drv_a(0, 0, 0, 0, 0); step();
    chk("xport_new", bus.q_b, 32'h12345678);
    chk("rd_only_no_col", 32'(bus.collision), 32'd0);

`ifdef RAM_PARITY_EN
    drv_b(0, 0, 0, 0, 0);
    inj = 1'b1; drv_a(1, 1, 4'hF, 2, 32'hCAFEF00D); step();
    inj = 1'b0; drv_a(1, 0, 0, 2, 0); step();
    chk("parity_inj", 32'(bus.parity_err_a), 32'd1);
    drv_a(1, 1, 4'hF, 2, 32'hCAFEF00D); step();
    drv_a(1, 0, 0, 2, 0); step();
    chk("parity_clean", 32'(bus.parity_err_a), 32'd0);
`endif

    repeat (400) begin rand_ports(); step(); end

    rand_ports(); bus.clr_req = 1'b1; step();
    bus.clr_req = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin rand_ports(); step(); n++; end
    chk("clr_len_req", 32'(n), 32'd64);
    inj = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      drv_a(1, 0, 0, 6'(k), 0); drv_b(1, 0, 0, 6'(DEPTH - 1 - k), 0); step();
      chk("cleared_a", bus.q_a, 32'h0);
    end

    rst_n = 1'b0; step(); rst_n = 1'b1;
    repeat (10) begin rand_ports(); step(); end
    rst_n = 1'b0; step(); rst_n = 1'b1;
    n = 0;
    while (bus.busy && n < 200) begin rand_ports(); step(); n++; end
    chk("clr_len_restart", 32'(n), 32'd64);
    repeat (100) begin rand_ports(); step(); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
